// File: rtl/cordic_rotator_if.sv
// Data bundle for cordic_rotator: input vector/phase in, rotated vector out.
interface cordic_rotator_if #(
    parameter int width = 16
);
    logic signed [width-1:0] Xin;
    logic signed [width-1:0] Yin;
    logic        [31:0]      angle;
    logic signed [width-1:0] COSout;
    logic signed [width-1:0] SINout;

    modport master (output Xin, Yin, angle, input  COSout, SINout);
    modport slave  (input  Xin, Yin, angle, output COSout, SINout);
endinterface

// File: rtl/cordic_rotator.sv
// Fully pipelined rotation-mode CORDIC, latency = width cycles, gain ~1.647 uncompensated.
// Define CORDIC_SATURATE_EN to saturate instead of wrap on output overflow.
module cordic_rotator #(
    parameter int width = 16
) (
    input  logic                   clk,
    cordic_rotator_if.slave        bus,
    input  logic                   rst_n
);
    localparam int XW = width + 1;
    localparam int NS = width;

    localparam logic [31:0] ATAN [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    logic signed [XW-1:0]    x_q [NS];
    logic signed [XW-1:0]    x_d [NS];
    logic signed [XW-1:0]    y_q [NS];
    logic signed [XW-1:0]    y_d [NS];
    // The last stage's phase is never consumed, so z stops one stage early.
    logic signed [31:0]      z_q [NS-1];
    logic signed [31:0]      z_d [NS-1];
    logic signed [width-1:0] cos_q, cos_d;
    logic signed [width-1:0] sin_q, sin_d;
    logic signed [XW-1:0]    xin_ext, yin_ext;

    function automatic logic signed [width-1:0] fit(input logic signed [XW-1:0] v);
`ifdef CORDIC_SATURATE_EN
        if (v[XW-1] != v[XW-2])
            fit = v[XW-1] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
        else
            fit = v[width-1:0];
`else
        fit = v[width-1:0];
`endif
    endfunction

    always_comb begin
        xin_ext = {bus.Xin[width-1], bus.Xin};
        yin_ext = {bus.Yin[width-1], bus.Yin};

        // Quadrant pre-rotation by +/-90 degrees brings the residual phase into [-90, 90).
        unique case (bus.angle[31:30])
            2'b01: begin
                x_d[0] = -yin_ext;
                y_d[0] = xin_ext;
                z_d[0] = {2'b00, bus.angle[29:0]};
            end
            2'b10: begin
                x_d[0] = yin_ext;
                y_d[0] = -xin_ext;
                z_d[0] = {2'b11, bus.angle[29:0]};
            end
            default: begin
                x_d[0] = xin_ext;
                y_d[0] = yin_ext;
                z_d[0] = bus.angle;
            end
        endcase

        for (int unsigned i = 0; i < NS - 1; i++) begin
            if (z_q[i][31]) begin
                x_d[i+1] = x_q[i] + (y_q[i] >>> i);
                y_d[i+1] = y_q[i] - (x_q[i] >>> i);
            end else begin
                x_d[i+1] = x_q[i] - (y_q[i] >>> i);
                y_d[i+1] = y_q[i] + (x_q[i] >>> i);
            end
        end

        for (int unsigned i = 0; i < NS - 2; i++) begin
            if (z_q[i][31])
                z_d[i+1] = z_q[i] + signed'(ATAN[i]);
            else
                z_d[i+1] = z_q[i] - signed'(ATAN[i]);
        end

        cos_d = fit(x_q[NS-1]);
        sin_d = fit(y_q[NS-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            for (int unsigned i = 0; i < NS - 1; i++) begin
                z_q[i] <= '0;
            end
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            cos_q <= cos_d;
            sin_q <= sin_d;
        end
    end

    assign bus.COSout = cos_q;
    assign bus.SINout = sin_q;
endmodule

// File: tb/tb_cordic_rotator.sv
// Directed scoreboard bench for cordic_rotator (width 16); expectations come from a real-valued rotation model.
module tb_cordic_rotator;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_rotator_if #(.width(W)) bus ();
    cordic_rotator #(.width(W)) dut (.clk(clk), .bus(bus.slave), .rst_n(rst_n));

    typedef struct {
        int due;
        int c;
        int s;
        int tol;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    real  kgain;

    localparam logic [31:0] A0   = 32'h00000000;
    localparam logic [31:0] A45  = 32'h20000000;
    localparam logic [31:0] A60  = 32'h2AAAAAAA;
    localparam logic [31:0] A75  = 32'h35555555;
    localparam logic [31:0] A90  = 32'h40000000;
    localparam logic [31:0] A180 = 32'h80000000;

    function automatic int fit_model(input real v);
        int e;
        logic signed [15:0] t;
        e = int'($floor(v + 0.5));
`ifdef CORDIC_SATURATE_EN
        if (e > 32767)  e = 32767;
        if (e < -32768) e = -32768;
        return e;
`else
        t = e[15:0];
        return int'(t);
`endif
    endfunction

    task automatic cmp(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        n_cmp++;
        assert ((d <= tol && d >= -tol) === 1'b1) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d: observed %0d expected %0d (+/-%0d)", tag, cyc, obs, exp, tol);
        end
    endtask

    task automatic check_out();
        exp_t e;
        int ec, es, tol;
        ec = 0; es = 0; tol = 0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e   = sb.pop_front();
            ec  = e.c;
            es  = e.s;
            tol = e.tol;
        end
        cmp("cos", int'(bus.COSout), ec, tol);
        cmp("sin", int'(bus.SINout), es, tol);
    endtask

    task automatic step(input int x, input int y, input logic [31:0] a, input int tol);
        exp_t e;
        real th;
        bus.Xin   = x[15:0];
        bus.Yin   = y[15:0];
        bus.angle = a;
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            th    = real'(a) * 2.0 * 3.14159265358979 / 4294967296.0;
            e.due = cyc + W;
            e.c   = fit_model(kgain * (real'(x) * $cos(th) - real'(y) * $sin(th)));
            e.s   = fit_model(kgain * (real'(x) * $sin(th) + real'(y) * $cos(th)));
            e.tol = tol;
            sb.push_back(e);
        end
        @(negedge clk);
        check_out();
    endtask

    task automatic mid_reset(input int hold);
        rst_n = 1'b0;
        #1;
        cmp("rst_cos", int'(bus.COSout), 0, 0);
        cmp("rst_sin", int'(bus.SINout), 0, 0);
        sb.delete();
        repeat (hold) step(19429, 0, A45, 16);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        real t;
        kgain = 1.0;
        t     = 1.0;
        for (int i = 0; i < W - 1; i++) begin
            kgain = kgain * $sqrt(1.0 + t * t);
            t     = t / 2.0;
        end

        repeat (3) step(19429, 0, A45, 16);
        rst_n = 1'b1;

        repeat (3) step(19429, 0, A45, 16);
        repeat (3) step(19429, 0, A75, 16);
        step(19429, 0, A90, 16);
        step(19429, 0, A180, 16);
        repeat (4) step(19429, 0, A0, 16);
        repeat (4) step(19429, 0, A60, 16);

        step(10000, 5000, 32'hC0000000, 24);
        step(-15000, 8000, 32'hE0000000, 24);
        step(0, -19000, 32'h90000000, 24);
        step(12000, -12000, 32'h60000000, 24);
        for (int i = 0; i < 8; i++) begin
            int rx, ry;
            rx = int'($urandom_range(26000)) - 13000;
            ry = int'($urandom_range(26000)) - 13000;
            step(rx, ry, $urandom(), 24);
        end
        repeat (6) step(19429, 0, A45, 16);

        mid_reset(2);
        rst_n = 1'b1;

        repeat (3) step(19429, 0, A75, 16);
        step(19429, 0, A90, 16);
        step(19429, 0, A180, 16);
        step(32767, 0, A0, 24);
        step(-32768, 0, A0, 24);
        repeat (20) step(0, 0, A0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
